// File: rtl/program_sequencer.sv
// Program memory and start/halt sequencer that replays stored opcodes to the
// 4-bit processor core, one per clock, stopping at HALT_OP, the last word or halt_req.
module program_sequencer #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [3:0]    prog_data,
  input  logic          start,
  input  logic          halt_req,
  output logic [3:0]    instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   issued_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] PC_ONE  = AW'(1);
  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    mem [DEPTH];

  logic [3:0]    instr_nxt;
  logic          valid_nxt;
  logic [AW-1:0] pc_nxt;
  logic [AW:0]   count_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  logic [AW-1:0] pc_inc;
  logic [3:0]    word_first;
  logic [3:0]    word_next;
  logic          run_end;

  function automatic logic [AW:0] count_inc(input logic [AW:0] count);
    count_inc = count + CNT_ONE;
  endfunction

  assign pc_inc     = pc + PC_ONE;
  assign word_first = mem[0];
  assign word_next  = mem[pc_inc];
  // pc == LAST_PC is tested before word_next, so the wrapped pc_inc is never used.
  assign run_end    = halt_req || (pc == LAST_PC) || (word_next == HALT_OP);

  // Program memory: writable only while not running, never cleared by reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state != RUN)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_nxt = state;
    instr_nxt = instruction;
    valid_nxt = instr_valid;
    pc_nxt    = pc;
    count_nxt = issued_count;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          pc_nxt    = '0;
          count_nxt = '0;
          // word_first is the pre-write value even if prog_we hits address 0 this cycle.
          if (word_first != HALT_OP) begin
            instr_nxt = word_first;
            valid_nxt = 1'b1;
            count_nxt = CNT_ONE;
            state_nxt = RUN;
          end else begin
            instr_nxt = '0;
            valid_nxt = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (run_end) begin
          instr_nxt = '0;
          valid_nxt = 1'b0;
          state_nxt = DONE;
        end else begin
          pc_nxt    = pc_inc;
          instr_nxt = word_next;
          count_nxt = count_inc(issued_count);
        end
      end
      default: begin
        instr_nxt = '0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      instruction  <= '0;
      instr_valid  <= 1'b0;
      pc           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
    end else begin
      state        <= state_nxt;
      instruction  <= instr_nxt;
      instr_valid  <= valid_nxt;
      pc           <= pc_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      issued_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: per-cycle expected outputs are queued
// as stimulus is driven and popped/compared one time unit after each rising edge.
module tb_program_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [3:0]    prog_data;
  logic          start;
  logic          halt_req;
  logic [3:0]    instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [AW:0]   issued_count;

  program_sequencer #(.DEPTH(DEPTH), .AW(AW), .HALT_OP(4'b1111)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .halt_req     (halt_req),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ins;
    logic       v;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic [4:0] cnt;
  } obs_t;

  obs_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] prog [8];

  function automatic obs_t mk(input logic [3:0] ins, input logic v, input logic [3:0] p,
                              input logic b, input logic d, input logic [4:0] c);
    mk = '{ins, v, p, b, d, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, e;
    for (int s = 0; s < 3; s++) begin
      rst      = (s < 2);
      halt_req = (s == 2);
      sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0));
      tick();
      got = {instruction, instr_valid, pc, busy, done, issued_count};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset[%0d] got ins/v/pc/busy/done/cnt=%h/%b/%0d/%b/%b/%0d want %h/%b/%0d/%b/%b/%0d",
                 s, got.ins, got.v, got.pc, got.busy, got.done, got.cnt, e.ins, e.v, e.pc, e.busy, e.done, e.cnt);
      end
    end
    halt_req = 1'b0;
  endtask

  task automatic test_straight();
    obs_t got, e;
    for (int i = 0; i < 8; i++) load(i[3:0], prog[i]);
    load(4'd8, 4'hF);
    for (int s = 0; s < 10; s++) begin
      start = (s == 0);
      if (s < 8) sb.push_back(mk(prog[s], 1'b1, s[3:0], 1'b1, 1'b0, 5'(s + 1)));
      else       sb.push_back(mk(4'h0, 1'b0, 4'd7, 1'b0, 1'b1, 5'd8));
      tick();
      got = {instruction, instr_valid, pc, busy, done, issued_count};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL straight[%0d] got ins/v/pc/busy/done/cnt=%h/%b/%0d/%b/%b/%0d want %h/%b/%0d/%b/%b/%0d",
                 s, got.ins, got.v, got.pc, got.busy, got.done, got.cnt, e.ins, e.v, e.pc, e.busy, e.done, e.cnt);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    obs_t got, e;
    for (int s = 0; s < 7; s++) begin
      start    = 1'b0;
      halt_req = 1'b0;
      prog_we  = 1'b0;
      case (s)
        0: begin start = 1'b1; sb.push_back(mk(4'h1, 1'b1, 4'd0, 1'b1, 1'b0, 5'd1)); end
        1: begin
          start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'hF;
          sb.push_back(mk(4'h2, 1'b1, 4'd1, 1'b1, 1'b0, 5'd2));
        end
        2: sb.push_back(mk(4'h3, 1'b1, 4'd2, 1'b1, 1'b0, 5'd3));
        3: begin halt_req = 1'b1; sb.push_back(mk(4'h0, 1'b0, 4'd2, 1'b0, 1'b1, 5'd3)); end
        4: begin start = 1'b1; sb.push_back(mk(4'h1, 1'b1, 4'd0, 1'b1, 1'b0, 5'd1)); end
        5: begin halt_req = 1'b1; sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd1)); end
        default: sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd1));
      endcase
      tick();
      got = {instruction, instr_valid, pc, busy, done, issued_count};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL abort[%0d] got ins/v/pc/busy/done/cnt=%h/%b/%0d/%b/%b/%0d want %h/%b/%0d/%b/%b/%0d",
                 s, got.ins, got.v, got.pc, got.busy, got.done, got.cnt, e.ins, e.v, e.pc, e.busy, e.done, e.cnt);
      end
    end
    start    = 1'b0;
    halt_req = 1'b0;
    prog_we  = 1'b0;
  endtask

  task automatic test_full();
    obs_t got, e;
    for (int i = 0; i < DEPTH; i++) load(i[3:0], 4'h1);
    for (int s = 0; s < DEPTH + 2; s++) begin
      start = (s == 0);
      if (s < DEPTH) sb.push_back(mk(4'h1, 1'b1, s[3:0], 1'b1, 1'b0, 5'(s + 1)));
      else           sb.push_back(mk(4'h0, 1'b0, 4'd15, 1'b0, 1'b1, 5'd16));
      tick();
      got = {instruction, instr_valid, pc, busy, done, issued_count};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL full[%0d] got ins/v/pc/busy/done/cnt=%h/%b/%0d/%b/%b/%0d want %h/%b/%0d/%b/%b/%0d",
                 s, got.ins, got.v, got.pc, got.busy, got.done, got.cnt, e.ins, e.v, e.pc, e.busy, e.done, e.cnt);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_immediate_halt();
    obs_t got, e;
    load(4'd0, 4'hF);
    for (int s = 0; s < 6; s++) begin
      start    = 1'b0;
      halt_req = 1'b0;
      prog_we  = 1'b0;
      case (s)
        0: begin start = 1'b1; sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd0)); end
        3: begin
          prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'h7;
          sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd0));
        end
        4: begin start = 1'b1; sb.push_back(mk(4'h7, 1'b1, 4'd0, 1'b1, 1'b0, 5'd1)); end
        5: begin halt_req = 1'b1; sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd1)); end
        default: sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd0));
      endcase
      tick();
      got = {instruction, instr_valid, pc, busy, done, issued_count};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL imm_halt[%0d] got ins/v/pc/busy/done/cnt=%h/%b/%0d/%b/%b/%0d want %h/%b/%0d/%b/%b/%0d",
                 s, got.ins, got.v, got.pc, got.busy, got.done, got.cnt, e.ins, e.v, e.pc, e.busy, e.done, e.cnt);
      end
    end
    start    = 1'b0;
    halt_req = 1'b0;
    prog_we  = 1'b0;
  endtask

  task automatic test_same_cycle();
    obs_t got, e;
    for (int s = 0; s < 6; s++) begin
      rst      = 1'b0;
      start    = 1'b0;
      halt_req = 1'b0;
      prog_we  = 1'b0;
      case (s)
        0: begin rst = 1'b1; sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0)); end
        1: begin
          prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'h1;
          sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0));
        end
        2: begin
          prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'h2; start = 1'b1;
          sb.push_back(mk(4'h1, 1'b1, 4'd0, 1'b1, 1'b0, 5'd1));
        end
        4: begin start = 1'b1; sb.push_back(mk(4'h2, 1'b1, 4'd0, 1'b1, 1'b0, 5'd1)); end
        default: begin halt_req = 1'b1; sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd1)); end
      endcase
      tick();
      got = {instruction, instr_valid, pc, busy, done, issued_count};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL same_cycle[%0d] got ins/v/pc/busy/done/cnt=%h/%b/%0d/%b/%b/%0d want %h/%b/%0d/%b/%b/%0d",
                 s, got.ins, got.v, got.pc, got.busy, got.done, got.cnt, e.ins, e.v, e.pc, e.busy, e.done, e.cnt);
      end
    end
    start    = 1'b0;
    halt_req = 1'b0;
    prog_we  = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    obs_t got, e;
    for (int i = 0; i < 8; i++) load(i[3:0], prog[i]);
    load(4'd8, 4'hF);
    for (int s = 0; s < 15; s++) begin
      rst      = (s == 3) || (s == 4);
      start    = (s == 0) || (s == 6);
      halt_req = (s == 5);
      if (s < 3)       sb.push_back(mk(prog[s], 1'b1, s[3:0], 1'b1, 1'b0, 5'(s + 1)));
      else if (s < 6)  sb.push_back(mk(4'h0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0));
      else if (s < 14) sb.push_back(mk(prog[s - 6], 1'b1, 4'(s - 6), 1'b1, 1'b0, 5'(s - 5)));
      else             sb.push_back(mk(4'h0, 1'b0, 4'd7, 1'b0, 1'b1, 5'd8));
      tick();
      got = {instruction, instr_valid, pc, busy, done, issued_count};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_mid[%0d] got ins/v/pc/busy/done/cnt=%h/%b/%0d/%b/%b/%0d want %h/%b/%0d/%b/%b/%0d",
                 s, got.ins, got.v, got.pc, got.busy, got.done, got.cnt, e.ins, e.v, e.pc, e.busy, e.done, e.cnt);
      end
    end
    rst      = 1'b0;
    start    = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    halt_req  = 1'b0;
    prog[0] = 4'h1; prog[1] = 4'h2; prog[2] = 4'h3; prog[3] = 4'h4;
    prog[4] = 4'h6; prog[5] = 4'h5; prog[6] = 4'h7; prog[7] = 4'h0;
    test_reset();
    test_straight();
    test_abort();
    test_full();
    test_immediate_halt();
    test_same_cycle();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
